// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Owns the program counter, presents it to the
// instruction memory (combinational read), and captures the returned word into
// the IF/ID pipeline register.
//
// It also handles:
//   - hazard stalls,
//   - taken-branch redirect with an IF/ID flush,
//   - HALT detection. When a HALT is detected, a drain FSM lets the older
//     instructions leave the pipe before the core freezes.
//
// Per-cycle priority: rst > branch_taken > stall > normal fetch.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous reset, active-high
//   stall          in   1   hazard unit: hold PC and IF/ID
//   branch_taken   in   1   branch resolved taken this cycle
//   branch_target  in  16   redirect address (bit0 forced to 0)
//   instruction    in  16   instruction memory data for from_pc
//   from_pc        out 16   current PC to instruction memory
//   ifid_instr     out 16   IF/ID instruction
//   ifid_pc_plus2  out 16   IF/ID PC+2 of the captured instruction
//   ifid_valid     out  1   IF/ID holds a real instruction
//   halted         out  1   core frozen after HALT drained
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, this module adds two saturating 16-bit counters:
//     fetch_count  IF/ID loads with valid=1
//     stall_count  stalled cycles while in RUN or DRAIN
//   When undefined, these ports and counters are absent.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] HALT_INSTR   = 16'h0000,
  parameter logic [15:0] NOP_INSTR    = 16'h0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] instruction,
  output logic [15:0] from_pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      instr_q, instr_d;
  logic [15:0]      pp2_q, pp2_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0]      pc_plus2;
  logic [15:0]      redirect_pc;

  // 16-bit add wraps naturally: FFFE + 2 -> 0000.
  assign pc_plus2    = pc_q + 16'd2;
  assign redirect_pc = {branch_target[15:1], 1'b0};

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so that
    // paths which leave a signal unassigned cannot infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pp2_d    = pp2_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_RUN: begin
        if (branch_taken) begin
          pc_d    = redirect_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = instruction;
          pp2_d   = pc_plus2;
          valid_d = 1'b1;
          if (instruction == HALT_INSTR) begin
            // The HALT itself goes down the pipe. The PC parks on it so that
            // nothing past the HALT is ever fetched.
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            pc_d = pc_plus2;
          end
        end
      end

      S_DRAIN: begin
        if (branch_taken) begin
          // An older branch resolved taken, so the HALT was on the wrong path.
          // Redirect and resume fetching.
          pc_d    = redirect_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (!stall) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end
        end
      end

      S_HALTED: begin
        // Frozen. Stall and branch inputs are ignored; only rst exits.
        halted_d = 1'b1;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pp2_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pp2_q    <= pp2_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign from_pc       = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus2 = pp2_q;
  assign ifid_valid    = valid_q;
  assign halted        = halted_q;

`ifdef FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        fetch_load;
  logic        stall_seen;

  // IF/ID takes a valid word only on an unstalled, unredirected RUN cycle.
  assign fetch_load = (state_q == S_RUN) && !branch_taken && !stall;
  assign stall_seen = (state_q != S_HALTED) && stall;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_load && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (stall_seen && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage with hand-computed expectations.
//
// The instruction memory is a 32K-word array, read combinationally through
// from_pc. Inputs are driven just after the falling edge, and outputs are
// checked at the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instruction;
  logic [15:0] from_pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  logic [15:0] mem [0:32767];

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .from_pc       (from_pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  assign instruction = mem[from_pc[15:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then stop at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h1111;
    mem[16'h0000 >> 1] = 16'hFE21;
    mem[16'h0002 >> 1] = 16'hFB22;
    mem[16'h0004 >> 1] = 16'h1234;
    mem[16'h0006 >> 1] = 16'h5678;
    mem[16'h003E >> 1] = 16'h0000;   // HALT
    mem[16'h0024 >> 1] = 16'h0000;   // HALT on a path that is later squashed
    mem[16'h0028 >> 1] = 16'h2A2A;
    mem[16'hFFFE >> 1] = 16'hABCD;

    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;

    // 1: reset
    @(negedge clk);
    tick();
    check("rst_pc",     from_pc,           16'h0000);
    check("rst_valid",  {15'd0, ifid_valid}, 16'd0);
    check("rst_halted", {15'd0, halted},   16'd0);
    check("rst_instr",  ifid_instr,        16'h0000);

    // 2: two normal fetches
    rst = 1'b0;
    tick();
    check("f1_instr", ifid_instr,          16'hFE21);
    check("f1_pp2",   ifid_pc_plus2,       16'h0002);
    check("f1_valid", {15'd0, ifid_valid}, 16'd1);
    tick();
    check("f2_instr", ifid_instr,    16'hFB22);
    check("f2_pp2",   ifid_pc_plus2, 16'h0004);
    check("f2_pc",    from_pc,       16'h0004);

    // 3: two stall cycles hold everything, then resume
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stl_pc",    from_pc,       16'h0004);
      check("stl_instr", ifid_instr,    16'hFB22);
      check("stl_pp2",   ifid_pc_plus2, 16'h0004);
      check("stl_valid", {15'd0, ifid_valid}, 16'd1);
    end
    stall = 1'b0;
    tick();
    check("res_pc",    from_pc,    16'h0006);
    check("res_instr", ifid_instr, 16'h1234);

    // 4: branch overrides a simultaneous stall; bit0 of the target is cleared
    branch_taken  = 1'b1;
    branch_target = 16'h0031;
    stall         = 1'b1;
    tick();
    check("br_pc",    from_pc,             16'h0030);
    check("br_valid", {15'd0, ifid_valid}, 16'd0);
    check("br_instr", ifid_instr,          16'h0000);
    branch_taken = 1'b0;
    stall        = 1'b0;

    // 5: run 0030..003C, then HALT at 003E
    for (int i = 0; i < 7; i++) tick();
    check("pre_halt_pc", from_pc, 16'h003E);
    tick();
    check("halt_instr", ifid_instr,          16'h0000);
    check("halt_valid", {15'd0, ifid_valid}, 16'd1);
    check("halt_pp2",   ifid_pc_plus2,       16'h0040);
    check("halt_pc",    from_pc,             16'h003E);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drain_valid",  {15'd0, ifid_valid}, 16'd0);
      check("drain_pc",     from_pc,             16'h003E);
      check("drain_halted", {15'd0, halted},     (i == 2) ? 16'd1 : 16'd0);
    end
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    stall         = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("frz_pc",     from_pc,             16'h003E);
      check("frz_halted", {15'd0, halted},     16'd1);
      check("frz_valid",  {15'd0, ifid_valid}, 16'd0);
    end
    branch_taken = 1'b0;
    stall        = 1'b0;

    // A reset while halted returns everything to the reset values
    rst = 1'b1;
    tick();
    check("rst2_pc",     from_pc,         16'h0000);
    check("rst2_halted", {15'd0, halted}, 16'd0);
    rst = 1'b0;

    // 6: HALT at 0024 squashed by a branch in the 2nd DRAIN cycle
    branch_taken  = 1'b1;
    branch_target = 16'h0024;
    tick();
    check("b24_pc", from_pc, 16'h0024);
    branch_taken = 1'b0;
    tick();
    check("h24_valid", {15'd0, ifid_valid}, 16'd1);
    check("h24_pc",    from_pc,             16'h0024);
    tick();
    check("d24_valid", {15'd0, ifid_valid}, 16'd0);
    branch_taken  = 1'b1;
    branch_target = 16'h0028;
    tick();
    check("sq_pc",     from_pc,         16'h0028);
    check("sq_halted", {15'd0, halted}, 16'd0);
    branch_taken = 1'b0;
    tick();
    check("sq_run_instr", ifid_instr,          16'h2A2A);
    check("sq_run_valid", {15'd0, ifid_valid}, 16'd1);
    check("sq_run_pc",    from_pc,             16'h002A);
    for (int i = 0; i < 4; i++) tick();
    check("sq_halted_late", {15'd0, halted}, 16'd0);

    // PC wraps: fetching at FFFE yields PC+2 = 0000
    branch_taken  = 1'b1;
    branch_target = 16'hFFFE;
    tick();
    check("wr_br_pc", from_pc, 16'hFFFE);
    branch_taken = 1'b0;
    tick();
    check("wr_instr", ifid_instr,    16'hABCD);
    check("wr_pp2",   ifid_pc_plus2, 16'h0000);
    check("wr_pc",    from_pc,       16'h0000);
    tick();
    check("wr_next_instr", ifid_instr, 16'hFE21);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
